// File: rtl/l2_pmem_burst_adaptor.sv
// Bridges one 256-bit L2 line transaction to a fixed 4-beat, 64-bit
// physical-memory burst and returns a single-cycle completion to L2.
module l2_pmem_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  output logic                resp_o,
  output logic                read_o,
  output logic                write_o,
  output logic [ADDR_W-1:0]   address_o,
  input  logic [BURST_W-1:0]  burst_i,
  output logic [BURST_W-1:0]  burst_o,
  input  logic                resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS  = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFFS) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LINE_W-1:0]   wline_reg, wline_next;
  logic [BURST_W-1:0]  rline_reg [BEATS];
  logic [BURST_W-1:0]  wbeat [BEATS];
  logic                last_beat;

  assign last_beat = resp_i && (cnt_reg == LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; read has priority over write in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (read_i) begin
          state_next = READ;
        end else if (write_i) begin
          state_next = WRITE;
        end
      end
      READ:    if (last_beat) state_next = DONE;
      WRITE:   if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic, decoded purely from state
  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    case (state_reg)
      READ: begin
        read_o    = 1'b1;
        address_o = addr_reg;
      end
      WRITE: begin
        write_o   = 1'b1;
        address_o = addr_reg;
        burst_o   = wbeat[cnt_reg];
      end
      DONE:    resp_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: request capture in IDLE, beat counting in bursts
  always_comb begin
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wline_next = wline_reg;
    case (state_reg)
      IDLE: begin
        if (read_i || write_i) begin
          addr_next = address_i & ALIGN_MASK;
          cnt_next  = '0;
          if (!read_i) begin
            wline_next = line_i;
          end
        end
      end
      READ, WRITE: begin
        if (resp_i) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wline_reg <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wline_reg <= wline_next;
    end
  end

  // Read beats land in their own slice; the line holds until the next read overwrites it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BEATS; i++) begin
        rline_reg[i] <= '0;
      end
    end else if (state_reg == READ && resp_i) begin
      for (int i = 0; i < BEATS; i++) begin
        if (cnt_reg == CNT_W'(i)) begin
          rline_reg[i] <= burst_i;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign wbeat[gi]                       = wline_reg[gi*BURST_W +: BURST_W];
      assign line_o[gi*BURST_W +: BURST_W]   = rline_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_l2_pmem_burst_adaptor.sv
// Randomized scoreboard bench: stimulus pushes expected line transactions,
// a memory responder serves/checks beats, a monitor checks each resp_o.
module tb_l2_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         reset;
  logic         read_i, write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i, burst_o;
  logic         resp_i;

  l2_pmem_burst_adaptor dut (
    .clk(clk), .reset(reset), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .read_o(read_o), .write_o(write_o), .address_o(address_o),
    .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_rd;
    logic [31:0]  addr;
    logic [255:0] line;
    int           lat;
    int           t0;
  } txn_t;

  txn_t         sb[$];
  logic [63:0]  rd_beats[$];
  logic [63:0]  wr_beats[$];
  bit           pat_q[$];
  bit           force_all = 1'b0;
  logic [255:0] last_line = '0;
  int           total = 0, bad = 0, resp_cnt = 0, cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Memory side: serves read beats, checks write beats and burst address/direction
  initial begin
    bit r;
    logic [63:0] eb;
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        resp_i = 1'b0;
      end else if (read_o || write_o) begin
        if (sb.size() == 0) begin
          chk("burst_without_txn", 256'(read_o | write_o), 256'd0);
        end else begin
          chk("address_o", 256'(address_o), 256'(sb[0].addr));
          chk("direction", 256'({read_o, write_o}), 256'(sb[0].is_rd ? 2'b10 : 2'b01));
        end
        if (pat_q.size() > 0) r = pat_q.pop_front();
        else if (force_all)   r = 1'b1;
        else                  r = ($urandom_range(0, 3) != 0);
        resp_i  = r;
        burst_i = {$urandom, $urandom};
        if (r && read_o) begin
          if (rd_beats.size() == 0) chk("read_beat_underflow", 256'd1, 256'd0);
          else burst_i = rd_beats.pop_front();
        end
        if (r && write_o) begin
          if (wr_beats.size() == 0) chk("write_beat_underflow", 256'd1, 256'd0);
          else begin
            eb = wr_beats.pop_front();
            chk("burst_o", 256'(burst_o), 256'(eb));
          end
        end
      end else begin
        // stray acknowledges outside a burst must be ignored
        resp_i  = 1'($urandom_range(0, 1));
        burst_i = {$urandom, $urandom};
      end
    end
  end

  // Completion monitor
  initial forever begin
    txn_t e;
    int lat;
    @(negedge clk);
    if (!reset && resp_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp_o", 256'd1, 256'd0);
      end else begin
        e = sb.pop_front();
        lat = cyc - e.t0 + 1;
        chk(e.is_rd ? "read_line_o" : "write_line_o_kept", line_o, e.line);
        if (e.lat != 0) chk("latency_exact", 256'(lat), 256'(e.lat));
        else            chk("latency_min", 256'(lat >= 6), 256'd1);
        $display("txn %0d %s addr=%h lat=%0d line_o=%h", resp_cnt, e.is_rd ? "RD" : "WR", e.addr, lat, line_o);
      end
      resp_cnt++;
    end
  end

  task automatic summary_and_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic wait_resp(input int target);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (resp_cnt >= target) return;
    end
    total++;
    bad++;
    $display("FAIL resp_timeout: got %0d responses want %0d", resp_cnt, target);
    summary_and_stop();
  endtask

  // Caller is at posedge+#1; returns at posedge+#1 with requests released
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] rdata,
                        input int lat, input bit drop);
    txn_t e;
    int base;
    base = resp_cnt;
    read_i = rd; write_i = wr; address_i = addr; line_i = wline;
    if (rd) begin
      e = '{1'b1, addr & ~32'h1f, rdata, lat, cyc};
      sb.push_back(e);
      for (int i = 0; i < 4; i++) rd_beats.push_back(rdata[i*64 +: 64]);
      last_line = rdata;
    end
    if (wr) begin
      e = '{1'b0, addr & ~32'h1f, last_line, rd ? 0 : lat, cyc};
      sb.push_back(e);
      for (int i = 0; i < 4; i++) wr_beats.push_back(wline[i*64 +: 64]);
    end
    if (drop) begin
      @(posedge clk);
      #1 read_i = 1'b0; write_i = 1'b0;
    end
    wait_resp(base + 1);
    #1 read_i = 1'b0;
    if (!(rd && wr)) write_i = 1'b0;
    if (rd && wr) begin
      wait_resp(base + 2);
      #1 write_i = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] d;
    reset = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; line_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_o", 256'(resp_o), 256'd0);
    chk("rst_read_o", 256'(read_o), 256'd0);
    chk("rst_write_o", 256'(write_o), 256'd0);
    chk("rst_address_o", 256'(address_o), 256'd0);
    chk("rst_burst_o", 256'(burst_o), 256'd0);
    chk("rst_line_o", line_o, 256'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // consecutive-beat read, then back-to-back write
    force_all = 1'b1;
    do_txn(1, 0, 32'h0000_1234, '0,
           {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 6, 0);
    do_txn(0, 1, 32'h8000_0040, rand_line(), '0, 6, 0);

    // gapped read
    force_all = 1'b0;
    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    do_txn(1, 0, 32'h0000_3fff, '0, rand_line(), 9, 0);

    // reset after two accepted read beats
    pat_q = '{1, 1, 0, 0, 0, 0, 0, 0};
    d = rand_line();
    read_i = 1'b1; address_i = 32'h0000_5550;
    sb.push_back('{1'b1, 32'h0000_5540, d, 0, cyc});
    for (int i = 0; i < 4; i++) rd_beats.push_back(d[i*64 +: 64]);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1; read_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_read_o", 256'(read_o), 256'd0);
    chk("midrst_resp_o", 256'(resp_o), 256'd0);
    chk("midrst_line_o", line_o, 256'd0);
    chk("midrst_address_o", 256'(address_o), 256'd0);
    sb.delete(); rd_beats.delete(); wr_beats.delete(); pat_q.delete();
    last_line = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    force_all = 1'b1;
    do_txn(1, 0, 32'h0000_5550, '0, rand_line(), 6, 0);

    // simultaneous read and write: read first, write served afterwards
    force_all = 1'b0;
    do_txn(1, 1, 32'hdead_beef, rand_line(), rand_line(), 0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      force_all = ($urandom_range(0, 3) == 0);
      case (kind)
        0, 1:    do_txn(1, 0, $urandom, '0, rand_line(), force_all ? 6 : 0, 1'($urandom_range(0, 1)));
        2, 3:    do_txn(0, 1, $urandom, rand_line(), '0, force_all ? 6 : 0, 1'($urandom_range(0, 1)));
        default: do_txn(1, 1, $urandom, rand_line(), rand_line(), 0, 0);
      endcase
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 256'(sb.size()), 256'd0);
    summary_and_stop();
  end

endmodule
